inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 14 +
 rtl/inst_fetch.sv | 120 ++++++++++++
 tb/tb_inst_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Program-memory read bus between inst_fetch (master) and instruction memory (slave).
// prog_data is valid in the same cycle that prog_ack is high.
interface inst_fetch_if #(
    parameter int unsigned PC_WIDTH   = 13,
    parameter int unsigned INST_WIDTH = 8
);
    logic                  prog_req;
    logic [PC_WIDTH-1:0]   prog_addr;
    logic                  prog_ack;
    logic [INST_WIDTH-1:0] prog_data;

    modport master (output prog_req, output prog_addr, input prog_ack, input prog_data);
    modport slave  (input prog_req, input prog_addr, output prog_ack, output prog_data);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequential fetch with jump/call/ret redirects.
// The return stack is built only when INST_FETCH_STACK_EN is defined.
module inst_fetch #(
    parameter int unsigned PC_WIDTH     = 13,
    parameter int unsigned INST_WIDTH   = 8,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_fetch_if.master          prog,
    input  logic                  stall,
    input  logic                  jump,
    input  logic                  call,
    input  logic                  ret,
    input  logic [PC_WIDTH-1:0]   target,
    output logic [INST_WIDTH-1:0] inst_reg,
    output logic                  inst_valid,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);
    typedef enum logic {StFill, StRun} state_e;

    localparam logic [PC_WIDTH-1:0] ResetPc = PC_WIDTH'(RESET_VECTOR);

    state_e                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  valid_q;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   redirect_pc;

    assign prog.prog_req  = ~stall & ~reset;
    assign prog.prog_addr = pc_q;
    assign pc             = pc_q;
    assign inst_reg       = inst_q;
    assign inst_valid     = valid_q;

`ifdef INST_FETCH_STACK_EN
    localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PtrW-1:0]     sp_q;
    logic [PtrW-1:0]     sp_inc;
    logic [PtrW-1:0]     sp_dec;
    logic [CntW-1:0]     cnt_q;
    logic                ovf_q;
    logic                unf_q;

    // sp_q points at the next free slot; when full that slot holds the oldest entry.
    assign sp_inc = (sp_q == PtrW'(STACK_DEPTH - 1)) ? '0 : sp_q + PtrW'(1);
    assign sp_dec = (sp_q == '0) ? PtrW'(STACK_DEPTH - 1) : sp_q - PtrW'(1);

    assign redirect        = ret | call | jump;
    assign redirect_pc     = ret ? ((cnt_q == '0) ? ResetPc : stack_q[sp_dec]) : target;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (cnt_q == '0) begin
                    unf_q <= 1'b1;
                end else begin
                    sp_q  <= sp_dec;
                    cnt_q <= cnt_q - CntW'(1);
                end
            end else if (call) begin
                stack_q[sp_q] <= pc_q;
                sp_q          <= sp_inc;
                if (cnt_q == CntW'(STACK_DEPTH)) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end
`else
    logic unused_ret;

    // Without a return stack, ret is inert and call degenerates to jump.
    assign unused_ret      = ret;
    assign redirect        = call | jump;
    assign redirect_pc     = target;
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFill;
            pc_q    <= ResetPc;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                // Any word acknowledged alongside a redirect is from the old stream.
                state_q <= StFill;
                pc_q    <= redirect_pc;
                inst_q  <= '0;
                valid_q <= 1'b0;
            end else if (prog.prog_ack) begin
                state_q <= StRun;
                pc_q    <= pc_q + PC_WIDTH'(1);
                inst_q  <= prog.prog_data;
                valid_q <= 1'b1;
            end else if (state_q == StRun) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios then random traffic
// against a queue-based reference model. Stack checks follow INST_FETCH_STACK_EN.
module tb_inst_fetch;
`ifdef INST_FETCH_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif
    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        stall, jump, call, ret;
    logic [12:0] target;
    logic [7:0]  inst_reg;
    logic        inst_valid;
    logic [12:0] pc;
    logic        stack_overflow, stack_underflow;

    inst_fetch_if #(.PC_WIDTH(13), .INST_WIDTH(8)) prog_bus ();

    inst_fetch #(
        .PC_WIDTH(13), .INST_WIDTH(8), .STACK_DEPTH(DEPTH), .RESET_VECTOR(0)
    ) dut (
        .clk(clk), .reset(reset), .prog(prog_bus.master),
        .stall(stall), .jump(jump), .call(call), .ret(ret), .target(target),
        .inst_reg(inst_reg), .inst_valid(inst_valid), .pc(pc),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state.
    int unsigned m_pc;
    logic [7:0]  m_inst;
    bit          m_valid, m_run, m_ovf, m_unf;
    int unsigned m_stack[$];
    logic [7:0]  key = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"}, 32'(pc), m_pc);
        check({tag, "_inst"}, 32'(inst_reg), 32'(m_inst));
        check({tag, "_valid"}, 32'(inst_valid), 32'(m_valid));
        check({tag, "_ovf"}, 32'(stack_overflow), 32'(m_ovf));
        check({tag, "_unf"}, 32'(stack_underflow), 32'(m_unf));
    endtask

    function automatic void model_reset();
        m_pc = 0; m_inst = 8'h00; m_valid = 0; m_run = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
    endfunction

    function automatic void model_step(input bit s, j, c, r, input int unsigned t,
                                       input logic [7:0] d, input bit a);
        if (s) return;
        if ((STACK_EN && r) || c || j) begin
            if (STACK_EN && r) begin
                if (m_stack.size() == 0) begin
                    m_pc = 0; m_unf = 1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else begin
                if (STACK_EN && c) begin
                    if (m_stack.size() == DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1;
                    end
                    m_stack.push_back(m_pc);
                end
                m_pc = t;
            end
            m_inst = 8'h00; m_valid = 0; m_run = 0;
        end else if (a) begin
            m_inst = d; m_valid = 1; m_pc = (m_pc + 1) % 8192; m_run = 1;
        end else if (m_run) begin
            m_valid = 0;
        end
    endfunction

    task automatic step(input string tag, input bit s, j, c, r, input logic [12:0] t,
                        input bit a);
        logic [7:0] d;
        @(negedge clk);
        d = 8'(m_pc) ^ key;
        reset = 1'b0; stall = s; jump = j; call = c; ret = r; target = t;
        prog_bus.prog_ack = a; prog_bus.prog_data = d;
        #1;
        check({tag, "_req"}, 32'(prog_bus.prog_req), 32'(!s));
        check({tag, "_addr"}, 32'(prog_bus.prog_addr), m_pc);
        @(posedge clk);
        model_step(s, j, c, r, 32'(t), d, a);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; stall = 1'($urandom); jump = 1'($urandom); call = 1'($urandom);
        ret = 1'($urandom); target = 13'($urandom); prog_bus.prog_ack = 1'b1;
        prog_bus.prog_data = 8'($urandom);
        #1;
        check({tag, "_req"}, 32'(prog_bus.prog_req), 32'd0);
        @(posedge clk);
        model_reset();
        #1;
        check_state(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 0; jump = 0; call = 0; ret = 0; target = '0;
        prog_bus.prog_ack = 1'b0; prog_bus.prog_data = '0;
        model_reset();

        do_reset("rst0");

        // Constant ack, data = addr[7:0].
        for (int i = 0; i < 4; i++) step("seq", 0, 0, 0, 0, 13'h0, 1);
        check("seq_inst3", 32'(inst_reg), 32'd3);
        check("seq_pc4", 32'(pc), 32'd4);
        step("seq", 0, 0, 0, 0, 13'h0, 1);

        // Stall at pc=5; redirects and ack must be ignored.
        step("stall", 1, 0, 0, 0, 13'h0, 1);
        step("stall", 1, 1, 1, 1, 13'h0777, 1);
        step("stall", 1, 0, 0, 0, 13'h0, 1);
        check("stall_pc5", 32'(pc), 32'd5);
        step("resume", 0, 0, 0, 0, 13'h0, 1);
        check("resume_inst5", 32'(inst_reg), 32'd5);
        step("bubble", 0, 0, 0, 0, 13'h0, 0);

        // Jump while acked discards the acked word.
        step("jump", 0, 1, 0, 0, 13'h0100, 1);
        check("jump_pc", 32'(pc), 32'h100);
        check("jump_valid", 32'(inst_valid), 32'd0);
        step("jfill", 0, 0, 0, 0, 13'h0, 1);
        check("jfill_pc", 32'(pc), 32'h101);

        // Call / ret.
        step("to10", 0, 1, 0, 0, 13'h0010, 0);
        step("call", 0, 0, 1, 0, 13'h0020, 1);
        check("call_pc", 32'(pc), 32'h20);
        step("ret", 0, 0, 0, 1, 13'h0, 1);
`ifdef INST_FETCH_STACK_EN
        check("ret_pc", 32'(pc), 32'h10);
        step("call2", 0, 0, 1, 0, 13'h0030, 1);
        step("retcall", 0, 0, 1, 1, 13'h0055, 1);
        check("retcall_pc", 32'(pc), 32'h10);
`else
        check("ret_noop_pc", 32'(pc), 32'h21);
`endif

        // Nine calls then nine rets.
        do_reset("rst1");
        for (int i = 0; i < 9; i++) step("ovf_call", 0, 0, 1, 0, 13'(32'h40 + i), 1);
        for (int i = 0; i < 9; i++) step("unf_ret", 0, 0, 0, 1, 13'h0, 0);
`ifdef INST_FETCH_STACK_EN
        check("unf_pc", 32'(pc), 32'd0);
        check("unf_flag", 32'(stack_underflow), 32'd1);
        check("ovf_flag", 32'(stack_overflow), 32'd1);
`else
        check("nostack_ovf", 32'(stack_overflow), 32'd0);
        check("nostack_unf", 32'(stack_underflow), 32'd0);
`endif
        for (int i = 0; i < 3; i++) step("sticky", 0, 0, 0, 0, 13'h0, 1);
        do_reset("rst2");

        // PC wrap, then reset during FILL with ack high.
        step("towrap", 0, 1, 0, 0, 13'h1FFF, 0);
        step("wrap", 0, 0, 0, 0, 13'h0, 1);
        check("wrap_pc", 32'(pc), 32'd0);
        step("tofill", 0, 1, 0, 0, 13'h0ABC, 0);
        do_reset("rst_fill");
        check("rst_fill_pc", 32'(pc), 32'd0);

        // Random traffic.
        key = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            bit s, j, c, r, a;
            if ($urandom_range(0, 63) == 0) begin
                do_reset("rnd_rst");
            end else begin
                s = ($urandom_range(0, 4) == 0);
                j = ($urandom_range(0, 9) == 0);
                c = ($urandom_range(0, 9) == 0);
                r = ($urandom_range(0, 7) == 0);
`ifndef INST_FETCH_STACK_EN
                r = r && !c && !j;
`endif
                a = ($urandom_range(0, 9) < 7);
                step("rnd", s, j, c, r, 13'($urandom), a);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
